// File: rtl/axi_burst_read_slave.sv
// AXI-style INCR burst read responder in front of a 1-cycle-latency word SRAM.
// One outstanding burst; a 2-entry credit-managed buffer absorbs R-channel back-pressure.
module axi_burst_read_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [3:0]        s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_rvalid,
    output logic              s_rlast,
    input  logic              s_rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              started_q;
    logic [3:0]        rem_q, rem_d;
    logic              mem_en_q, mem_en_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              issue_last_q, issue_last_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic [DATA_W-1:0] fifo_data_q [0:1];
    logic [DATA_W-1:0] fifo_data_d [0:1];
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic       fifo_nonempty, beat_pop, ar_hs, push, fifo_pop;
    logic [2:0] occ;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{s_araddr[1:0], s_araddr[ADDR_W-1:MEM_AW+2]};

    assign s_arready     = started_q & (state_q == ST_IDLE);
    assign fifo_nonempty = (count_q != 2'd0);
    // The beat returning from the SRAM is presented directly when the buffer is empty.
    assign s_rvalid = fifo_nonempty | pend_q;
    assign s_rdata  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : (pend_q ? mem_rdata : '0);
    assign s_rlast  = fifo_nonempty ? fifo_last_q[rd_ptr_q] : (pend_q & pend_last_q);
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;

    assign beat_pop = s_rvalid & s_rready;
    assign ar_hs    = s_arvalid & s_arready;
    assign push     = pend_q & (fifo_nonempty | ~s_rready);
    assign fifo_pop = fifo_nonempty & s_rready;
    assign occ      = {1'b0, count_q} + {2'b00, mem_en_q} + {2'b00, pend_q};

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        issue_last_d = 1'b0;
        pend_d       = mem_en_q;
        pend_last_d  = issue_last_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d      = ST_BURST;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = s_araddr[MEM_AW+1:2];
                    rem_d        = s_arlen;
                    issue_last_d = (s_arlen == 4'd0);
                end
            end
            default: begin
                // Issue only when every word already owed has a buffer slot, or one frees now.
                if ((rem_q != 4'd0) && ((occ < 3'd2) || beat_pop)) begin
                    mem_en_d     = 1'b1;
                    mem_addr_d   = mem_addr_q + 1'b1;
                    rem_d        = rem_q - 4'd1;
                    issue_last_d = (rem_q == 4'd1);
                end
                if (beat_pop && s_rlast) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_last_d[wr_ptr_q] = pend_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, fifo_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            started_q      <= 1'b0;
            rem_q          <= '0;
            mem_en_q       <= 1'b0;
            mem_addr_q     <= '0;
            issue_last_q   <= 1'b0;
            pend_q         <= 1'b0;
            pend_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            started_q      <= 1'b1;
            rem_q          <= rem_d;
            mem_en_q       <= mem_en_d;
            mem_addr_q     <= mem_addr_d;
            issue_last_q   <= issue_last_d;
            pend_q         <= pend_d;
            pend_last_q    <= pend_last_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_read_slave.sv
// Bench for axi_burst_read_slave: directed and randomized bursts against a queue-based
// reference of expected beats derived from the address/length rules and a memory image.
module tb_axi_burst_read_slave;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MAW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  s_araddr;
    logic [3:0]     s_arlen;
    logic           s_arvalid;
    logic           s_arready;
    logic [DW-1:0]  s_rdata;
    logic           s_rvalid;
    logic           s_rlast;
    logic           s_rready;
    logic           mem_en;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata;

    axi_burst_read_slave #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW)) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<MAW)-1];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    beat_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = -100;
    int prev_burst_last = -100;
    int burst_beats = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = -100;
    int stall_cnt = 0;
    logic [MAW-1:0] burst_base;
    logic rr_random = 1'b0;
    logic stall_armed = 1'b0;
    logic req_pending = 1'b0;
    logic [AW-1:0] req_addr;
    logic [3:0] req_len;
    logic ar_clear = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: beat i of a burst reads word (addr/4 + i) mod 2^MAW; last flag on beat len.
    task automatic push_expect(input logic [AW-1:0] addr, input logic [3:0] len);
        logic [MAW-1:0] w;
        for (int i = 0; i <= int'(len); i++) begin
            w = addr[MAW+1:2] + MAW'(i);
            exp_q.push_back('{d: mem[w], l: (i == int'(len))});
        end
    endtask

    task automatic request(input logic [AW-1:0] addr, input logic [3:0] len);
        req_addr    = addr;
        req_len     = len;
        req_pending = 1'b1;
    endtask

    task automatic cycle();
        beat_t e;
        @(negedge clk);
        cyc++;
        if (ar_clear) begin s_arvalid = 1'b0; ar_clear = 1'b0; end
        if (req_pending && !s_arvalid) begin
            s_araddr = req_addr; s_arlen = req_len; s_arvalid = 1'b1; req_pending = 1'b0;
        end
        if (!rr_random) s_rready = 1'b1;
        else begin
            if (stall_armed && burst_beats == 8) begin stall_cnt = 5; stall_armed = 1'b0; end
            if (stall_cnt > 0) begin s_rready = 1'b0; stall_cnt--; end
            else s_rready = 1'($urandom_range(0, 1));
        end
        if (prev_stall) begin
            chk("stall_rvalid", 32'(s_rvalid), 32'd1);
            chk("stall_rdata", s_rdata, prev_data);
            chk("stall_rlast", 32'(s_rlast), 32'(prev_last));
        end
        if (cyc == hs_cyc + 1) begin
            chk("mem_en_T1", 32'(mem_en), 32'd1);
            chk("mem_addr_T1", 32'(mem_addr), 32'(burst_base));
        end
        if (s_rvalid && s_rready) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'(s_rvalid), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rdata", s_rdata, e.d);
                chk("rlast", 32'(s_rlast), 32'(e.l));
                if (burst_beats == 0) first_beat_cyc = cyc;
                burst_beats++;
                last_beat_cyc = cyc;
            end
        end
        prev_stall = s_rvalid && !s_rready;
        prev_data  = s_rdata;
        prev_last  = s_rlast;
        if (s_arvalid && s_arready) begin
            prev_burst_last = last_beat_cyc;
            hs_cyc      = cyc;
            burst_beats = 0;
            burst_base  = s_araddr[MAW+1:2];
            push_expect(s_araddr, s_arlen);
            ar_clear = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (exp_q.size() == 0 && !req_pending && !s_arvalid) done = 1'b1;
            else cycle();
        end
        if (!done) chk("timeout_pending_beats", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int guard;
        for (int i = 0; i < (1 << MAW); i++) mem[i] = $urandom;
        rst = 1'b1; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        #2;
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rlast", 32'(s_rlast), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        cycle(); cycle();
        rst = 1'b0;
        chk("arready_at_release", 32'(s_arready), 32'd0);
        cycle();
        chk("arready_after_release", 32'(s_arready), 32'd1);

        // Single-word uncached read
        mem[16'h0100] = 32'hDEADBEEF;
        request(32'h400, 4'd0);
        wait_done(50);
        chk("t1_first_lat", 32'(first_beat_cyc), 32'(hs_cyc + 2));
        chk("t1_beats", 32'(burst_beats), 32'd1);
        cycle();
        chk("t1_arready_T3", 32'(s_arready), 32'd1);
        chk("t1_arready_cyc", 32'(cyc), 32'(hs_cyc + 3));
        cycle(); cycle();

        // 16-beat cache line, rready held high
        for (int i = 0; i < 16; i++) mem[16'h0040 + i] = 32'(i) * 32'h11111111;
        request(32'h100, 4'd15);
        wait_done(100);
        chk("t2_first_lat", 32'(first_beat_cyc), 32'(hs_cyc + 2));
        chk("t2_last_lat", 32'(last_beat_cyc), 32'(hs_cyc + 17));
        chk("t2_beats", 32'(burst_beats), 32'd16);
        cycle();
        chk("t2_arready_T18", 32'(s_arready), 32'd1);

        // Same line under random back-pressure with a 5-cycle stall, then random bursts
        rr_random = 1'b1; stall_armed = 1'b1;
        request(32'h100, 4'd15);
        wait_done(300);
        chk("t3_beats", 32'(burst_beats), 32'd16);
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            request(ra, 4'($urandom_range(0, 15)));
            wait_done(300);
        end
        rr_random = 1'b0;

        // Back-to-back: second request raised while first burst is streaming
        request(32'h100, 4'd15);
        guard = 0;
        while ((hs_cyc < 0 || burst_beats < 3 || exp_q.size() == 0) && guard < 100) begin
            cycle(); guard++;
        end
        request(32'h2000, 4'd3);
        wait_done(200);
        chk("t4_accept_after_rlast", 32'(hs_cyc), 32'(prev_burst_last + 1));
        chk("t4_second_beats", 32'(burst_beats), 32'd4);

        // Word-address wrap at top of SRAM
        request(32'h0003FFF8, 4'd3);
        wait_done(100);
        chk("t5_beats", 32'(burst_beats), 32'd4);

        // Reset while the 7th beat of a line is on the bus
        request(32'h100, 4'd15);
        guard = 0;
        while ((hs_cyc < 0 || burst_beats < 6 || exp_q.size() == 0) && guard < 100) begin
            cycle(); guard++;
        end
        chk("t6_beats_before_rst", 32'(burst_beats), 32'd6);
        @(posedge clk); #1;
        chk("t6_beat7_valid", 32'(s_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
        chk("t6_rst_rdata", s_rdata, 32'd0);
        chk("t6_rst_rlast", 32'(s_rlast), 32'd0);
        chk("t6_rst_arready", 32'(s_arready), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        hs_cyc = -100;
        ar_clear = 1'b0; s_arvalid = 1'b0;
        cycle(); cycle();
        chk("t6_no_beats_in_rst", 32'(s_rvalid), 32'd0);
        rst = 1'b0;
        cycle();
        chk("t6_arready_after", 32'(s_arready), 32'd1);
        mem[16'h0077] = 32'hC0FFEE11;
        request(32'h1DC, 4'd0);
        wait_done(50);
        chk("t6_single_beats", 32'(burst_beats), 32'd1);
        chk("t6_single_lat", 32'(first_beat_cyc), 32'(hs_cyc + 2));
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
